// File: rtl/jt51_slot_pkg.sv
// Shared types and helpers for the jt51 slot ring and its request controllers.
package jt51_slot_pkg;

  typedef enum logic {SLOT_IDLE, SLOT_WAIT} slot_fsm_t;

  function automatic int slot_w(input int stages);
    return (stages > 1) ? $clog2(stages) : 1;
  endfunction

endpackage

// File: rtl/jt51_slot_ctl.sv
// Single-request controller: latch a target slot, wait for it at the ring output, pulse ack.
// Out-of-range slots are acknowledged on the next clock without ever going busy.
module jt51_slot_ctl
  import jt51_slot_pkg::*;
#(
  parameter int stages = 32,
  parameter int SW     = slot_w(stages)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          cen_i,
  input  logic          req_i,
  input  logic [SW-1:0] slot_i,
  input  logic [SW-1:0] cur_slot_i,
  output logic          accept_o,
  output logic          hit_o,
  output logic          busy_o,
  output logic          ack_o
);

  slot_fsm_t     state_q, state_d;
  logic [SW-1:0] slot_q;
  logic          ack_q, ack_d;
  logic          in_range;

  assign in_range = {1'b0, slot_i} < (SW+1)'(stages);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= SLOT_IDLE;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ack_q   <= ack_d;
    end
    if (accept_o) slot_q <= slot_i;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      SLOT_IDLE: if (req_i && in_range) state_d = SLOT_WAIT;
      SLOT_WAIT: if (cen_i && hit_o) state_d = SLOT_IDLE;
      default:   state_d = SLOT_IDLE;
    endcase
  end

  // Discarded (out-of-range) requests ack straight from IDLE.
  always_comb begin
    busy_o   = (state_q == SLOT_WAIT);
    hit_o    = busy_o && (slot_q == cur_slot_i);
    accept_o = (state_q == SLOT_IDLE) && req_i && in_range;
    ack_d    = ((state_q == SLOT_IDLE) && req_i && !in_range) || (cen_i && hit_o);
  end

  assign ack_o = ack_q;

endmodule

// File: rtl/jt51_slot_ring.sv
// Recirculating per-slot parameter ring for the jt51 operator pipeline with random-access writes.
// Define JT51_SLOT_RD_EN to add a matching random-access read port.
module jt51_slot_ring
  import jt51_slot_pkg::*;
#(
  parameter int   width  = 5,
  parameter int   stages = 32,
  parameter logic rstval = 1'b0,
  localparam int  SW     = slot_w(stages)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cen,
  input  logic             wr_req,
  input  logic [SW-1:0]    wr_slot,
  input  logic [width-1:0] wr_data,
  output logic             wr_busy,
  output logic             wr_ack,
  output logic [SW-1:0]    cur_slot,
  output logic [width-1:0] drop
`ifdef JT51_SLOT_RD_EN
  ,
  input  logic             rd_req,
  input  logic [SW-1:0]    rd_slot,
  output logic [width-1:0] rd_data,
  output logic             rd_busy,
  output logic             rd_ack
`endif
);

  logic [SW-1:0]    cur_slot_q, cur_slot_d;
  logic [width-1:0] wr_data_q;
  logic [width-1:0] ring_q [stages];
  logic [width-1:0] tail;
  logic             wr_accept, wr_hit;

  jt51_slot_ctl #(.stages(stages), .SW(SW)) u_wr (
    .clk_i      (clk),
    .rst_i      (rst),
    .cen_i      (cen),
    .req_i      (wr_req),
    .slot_i     (wr_slot),
    .cur_slot_i (cur_slot_q),
    .accept_o   (wr_accept),
    .hit_o      (wr_hit),
    .busy_o     (wr_busy),
    .ack_o      (wr_ack)
  );

  always_comb begin
    cur_slot_d = cur_slot_q;
    if (cen) cur_slot_d = (cur_slot_q == SW'(stages - 1)) ? '0 : cur_slot_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) cur_slot_q <= '0;
    else     cur_slot_q <= cur_slot_d;
  end

  always_ff @(posedge clk) begin
    if (wr_accept) wr_data_q <= wr_data;
  end

  // Data bits carry no reset so the ring maps onto shift-register primitives;
  // clearing relies on rst forcing the tail for a full lap.
  assign tail = rst ? {width{rstval}} : (wr_hit ? wr_data_q : ring_q[stages-1]);

  always_ff @(posedge clk) begin
    if (cen) begin
      ring_q[0] <= tail;
      for (int k = 1; k < stages; k++) ring_q[k] <= ring_q[k-1];
    end
  end

  assign drop     = rst ? {width{rstval}} : ring_q[stages-1];
  assign cur_slot = cur_slot_q;

`ifdef JT51_SLOT_RD_EN
  logic             rd_accept, rd_hit;
  logic [width-1:0] rd_data_q;

  jt51_slot_ctl #(.stages(stages), .SW(SW)) u_rd (
    .clk_i      (clk),
    .rst_i      (rst),
    .cen_i      (cen),
    .req_i      (rd_req),
    .slot_i     (rd_slot),
    .cur_slot_i (cur_slot_q),
    .accept_o   (rd_accept),
    .hit_o      (rd_hit),
    .busy_o     (rd_busy),
    .ack_o      (rd_ack)
  );

  // Capturing drop (pre-write) makes a same-cen read+write return the old value.
  always_ff @(posedge clk) begin
    if (rst)                                 rd_data_q <= '0;
    else if (cen && rd_hit)                  rd_data_q <= drop;
    else if (rd_req && !rd_busy && !rd_accept) rd_data_q <= '0;
  end

  assign rd_data = rd_data_q;
`endif

endmodule

// File: tb/tb_jt51_slot_ring.sv
// Scoreboard bench for jt51_slot_ring: 32-slot ring (rstval=1) and 24-slot ring (rstval=0).
module tb_jt51_slot_ring;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cen = 1'b1;

  logic       a_wr_req = 1'b0, b_wr_req = 1'b0;
  logic [4:0] a_wr_slot = '0, b_wr_slot = '0;
  logic [4:0] a_wr_data = '0, b_wr_data = '0;
  logic       a_wr_busy, a_wr_ack, b_wr_busy, b_wr_ack;
  logic [4:0] a_cur, a_drop, b_cur, b_drop;
`ifdef JT51_SLOT_RD_EN
  logic       a_rd_req = 1'b0, b_rd_req = 1'b0;
  logic [4:0] a_rd_slot = '0, b_rd_slot = '0;
  logic [4:0] a_rd_data, b_rd_data;
  logic       a_rd_busy, a_rd_ack, b_rd_busy, b_rd_ack;
`endif

  always #5 clk = ~clk;

  jt51_slot_ring #(.width(5), .stages(32), .rstval(1'b1)) dut_a (
    .clk(clk), .rst(rst), .cen(cen),
    .wr_req(a_wr_req), .wr_slot(a_wr_slot), .wr_data(a_wr_data),
    .wr_busy(a_wr_busy), .wr_ack(a_wr_ack), .cur_slot(a_cur), .drop(a_drop)
`ifdef JT51_SLOT_RD_EN
    , .rd_req(a_rd_req), .rd_slot(a_rd_slot), .rd_data(a_rd_data),
    .rd_busy(a_rd_busy), .rd_ack(a_rd_ack)
`endif
  );

  jt51_slot_ring #(.width(5), .stages(24), .rstval(1'b0)) dut_b (
    .clk(clk), .rst(rst), .cen(cen),
    .wr_req(b_wr_req), .wr_slot(b_wr_slot), .wr_data(b_wr_data),
    .wr_busy(b_wr_busy), .wr_ack(b_wr_ack), .cur_slot(b_cur), .drop(b_drop)
`ifdef JT51_SLOT_RD_EN
    , .rd_req(b_rd_req), .rd_slot(b_rd_slot), .rd_data(b_rd_data),
    .rd_busy(b_rd_busy), .rd_ack(b_rd_ack)
`endif
  );

  typedef struct {
    logic [4:0] slot;
    logic [4:0] val;
  } drop_t;

  drop_t      a_dq[$], b_dq[$];
  logic [4:0] a_aq[$], b_aq[$];
  logic [4:0] rd_q[$];
  int n_cmp = 0;
  int n_bad = 0;
  int a_acks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: bound expired, got nothing expected event", name);
  endtask

  // Monitor: pops expectations when the DUTs present acks or the awaited slot reaches drop.
  initial begin : monitor
    int a_age = 0;
    int b_age = 0;
    forever begin
      @(negedge clk);
      if (a_wr_ack) begin
        a_acks++;
        if (a_aq.size() == 0) check("a_unexpected_ack", 32'd1, 32'd0);
        else check("a_ack_cur_slot", a_cur, a_aq.pop_front());
      end
      if (b_wr_ack) begin
        if (b_aq.size() == 0) check("b_unexpected_ack", 32'd1, 32'd0);
        else check("b_ack_cur_slot", b_cur, b_aq.pop_front());
      end
`ifdef JT51_SLOT_RD_EN
      if (a_rd_ack) begin
        if (rd_q.size() == 0) check("a_unexpected_rd_ack", 32'd1, 32'd0);
        else check("a_rd_data", a_rd_data, rd_q.pop_front());
      end
`endif
      if (!rst && a_dq.size() != 0) begin
        if (a_cur == a_dq[0].slot) begin
          check($sformatf("a_drop_slot%0d", a_dq[0].slot), a_drop, a_dq[0].val);
          void'(a_dq.pop_front());
          a_age = 0;
        end else if (++a_age > 200) begin
          fail("a_drop_wait");
          void'(a_dq.pop_front());
          a_age = 0;
        end
      end
      if (!rst && b_dq.size() != 0) begin
        if (b_cur == b_dq[0].slot) begin
          check($sformatf("b_drop_slot%0d", b_dq[0].slot), b_drop, b_dq[0].val);
          void'(b_dq.pop_front());
          b_age = 0;
        end else if (++b_age > 200) begin
          fail("b_drop_wait");
          void'(b_dq.pop_front());
          b_age = 0;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_slot_a(input logic [4:0] s);
    int n = 0;
    while (a_cur != s && n < 100) begin tick(); n++; end
    if (a_cur != s) fail("a_wait_slot");
  endtask

  task automatic wait_slot_b(input logic [4:0] s);
    int n = 0;
    while (b_cur != s && n < 100) begin tick(); n++; end
    if (b_cur != s) fail("b_wait_slot");
  endtask

  task automatic wait_ack_a();
    int n = 0;
    while (!a_wr_ack && n < 100) begin tick(); n++; end
    if (!a_wr_ack) fail("a_ack_wait");
  endtask

  task automatic wait_ack_b();
    int n = 0;
    while (!b_wr_ack && n < 100) begin tick(); n++; end
    if (!b_wr_ack) fail("b_ack_wait");
  endtask

  task automatic drain();
    int n = 0;
    while ((a_dq.size() != 0 || b_dq.size() != 0) && n < 400) begin tick(); n++; end
  endtask

  initial begin : stimulus
    int acks_before;
    drop_t e;

    // Hold reset for more than a full lap with cen running.
    repeat (3) tick();
    check("a_drop_in_rst", a_drop, 5'h1F);
    check("a_cur_in_rst", a_cur, 5'd0);
    check("a_busy_in_rst", a_wr_busy, 1'b0);
    check("a_ack_in_rst", a_wr_ack, 1'b0);
    check("b_drop_in_rst", b_drop, 5'h00);
    repeat (34) tick();
    rst = 1'b0;
    for (int i = 0; i < 32; i++) begin e.slot = 5'(i); e.val = 5'h1F; a_dq.push_back(e); end
    for (int i = 0; i < 24; i++) begin e.slot = 5'(i); e.val = 5'h00; b_dq.push_back(e); end
    drain();

    // Write slot 10 from cur_slot 3: commit when slot 10 passes, ack seen at cur_slot 11.
    wait_slot_a(5'd3);
    a_wr_req = 1'b1; a_wr_slot = 5'd10; a_wr_data = 5'h15;
    a_aq.push_back(5'd11);
    tick();
    a_wr_req = 1'b0;
    check("a_busy_after_req", a_wr_busy, 1'b1);
    wait_ack_a();
    e.slot = 5'd10; e.val = 5'h15; a_dq.push_back(e); a_dq.push_back(e);
    e.slot = 5'd11; e.val = 5'h1F; a_dq.push_back(e);
    drain();

    // Write slot 4 while slot 4 is at the output: old value this lap, new value next lap.
    wait_slot_a(5'd4);
    cen = 1'b0;
    a_wr_req = 1'b1; a_wr_slot = 5'd4; a_wr_data = 5'h0A;
    e.slot = 5'd4; e.val = 5'h1F; a_dq.push_back(e);
    tick();
    a_wr_req = 1'b0;
    cen = 1'b1;
    a_aq.push_back(5'd5);
    check("a_hold_cur_cen0", a_cur, 5'd4);
    check("a_hold_drop_cen0", a_drop, 5'h1F);
    check("a_busy_cen0", a_wr_busy, 1'b1);
    tick();
    check("a_ack_same_slot", a_wr_ack, 1'b1);
    e.slot = 5'd4; e.val = 5'h0A; a_dq.push_back(e);
    drain();

    // Second request while busy must be ignored.
    wait_slot_a(5'd15);
    a_wr_req = 1'b1; a_wr_slot = 5'd20; a_wr_data = 5'h07;
    a_aq.push_back(5'd21);
    tick();
    a_wr_slot = 5'd21; a_wr_data = 5'h1C;
    tick();
    tick();
    a_wr_req = 1'b0;
    wait_ack_a();
    e.slot = 5'd20; e.val = 5'h07; a_dq.push_back(e);
    e.slot = 5'd21; e.val = 5'h1F; a_dq.push_back(e);
    drain();

    // 24-slot ring: valid write, then out-of-range slot 30.
    wait_slot_b(5'd2);
    b_wr_req = 1'b1; b_wr_slot = 5'd5; b_wr_data = 5'h13;
    b_aq.push_back(5'd6);
    tick();
    b_wr_req = 1'b0;
    wait_ack_b();
    e.slot = 5'd5; e.val = 5'h13; b_dq.push_back(e);
    drain();
    wait_slot_b(5'd10);
    b_wr_req = 1'b1; b_wr_slot = 5'd30; b_wr_data = 5'h1F;
    b_aq.push_back(5'd11);
    tick();
    b_wr_req = 1'b0;
    check("b_oor_ack", b_wr_ack, 1'b1);
    check("b_oor_busy", b_wr_busy, 1'b0);
    e.slot = 5'd23; e.val = 5'h00; b_dq.push_back(e);
    e.slot = 5'd0;  e.val = 5'h00; b_dq.push_back(e);
    e.slot = 5'd5;  e.val = 5'h13; b_dq.push_back(e);
    e.slot = 5'd6;  e.val = 5'h00; b_dq.push_back(e);
    drain();

`ifdef JT51_SLOT_RD_EN
    wait_slot_a(5'd20);
    a_wr_req = 1'b1; a_wr_slot = 5'd7; a_wr_data = 5'h02;
    a_aq.push_back(5'd8);
    tick();
    a_wr_req = 1'b0;
    wait_ack_a();
    wait_slot_a(5'd7);
    cen = 1'b0;
    a_wr_req = 1'b1; a_wr_slot = 5'd7; a_wr_data = 5'h0C;
    a_rd_req = 1'b1; a_rd_slot = 5'd7;
    rd_q.push_back(5'h02);
    a_aq.push_back(5'd8);
    tick();
    a_wr_req = 1'b0; a_rd_req = 1'b0;
    cen = 1'b1;
    tick();
    check("a_rd_ack_same_cen", a_rd_ack, 1'b1);
    wait_slot_a(5'd3);
    a_rd_req = 1'b1; a_rd_slot = 5'd7;
    rd_q.push_back(5'h0C);
    tick();
    a_rd_req = 1'b0;
    repeat (10) tick();
`endif

    // Reset while a write is pending: busy clears and no ack ever appears.
    wait_slot_a(5'd0);
    a_wr_req = 1'b1; a_wr_slot = 5'd25; a_wr_data = 5'h11;
    tick();
    a_wr_req = 1'b0;
    check("a_busy_before_rst", a_wr_busy, 1'b1);
    tick();
    acks_before = a_acks;
    rst = 1'b1;
    tick();
    check("a_busy_cleared_by_rst", a_wr_busy, 1'b0);
    check("a_cur_cleared_by_rst", a_cur, 5'd0);
    rst = 1'b0;
    repeat (40) tick();
    check("a_no_ack_after_rst", a_acks, acks_before);
    check("a_busy_idle_after_rst", a_wr_busy, 1'b0);

    check("a_ack_queue_empty", a_aq.size(), 0);
    check("b_ack_queue_empty", b_aq.size(), 0);
    check("a_drop_queue_empty", a_dq.size(), 0);
    check("b_drop_queue_empty", b_dq.size(), 0);
    check("rd_queue_empty", rd_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
